us_scan_timing_gen: RTL and testbench



---
 rtl/us_scan_timing_gen.sv | 319 +++++++++++++++++++++++++++++++
 tb/tb_us_scan_timing_gen.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/us_scan_timing_gen.sv
// ---------------------------------------------------------------------------
// us_scan_timing_gen
//
// Purpose:
//    Generates the per-line acquisition timing presented to the CC3200 host.
//    Each scan line is one Envelop pulse followed by FOCUS_ZONES RX_Gate
//    pulses, then a LINE_GAP idle stretch. The module also tracks the current
//    line index and the focus code (00 -> 10 -> 11 -> 00) that the host
//    decodes, and handles frame start/stop requests from the scan controller.
//
// Ports:
//    clk_in      in   1  system clock
//    reset_n     in   1  asynchronous active-low reset
//    start       in   1  single-cycle frame start request (ignored while busy)
//    stop        in   1  single-cycle graceful stop (current line completes)
//    envelop     out  1  line-start pulse to host, registered
//    rx_gate     out  1  focal-zone gate pulse to host, registered
//    line_idx    out  8  index of the current line, 0-based
//    focus_idx   out  2  focus code, advances on each rx_gate rise
//    busy        out  1  high whenever the FSM is not idle
//    frame_done  out  1  one-cycle pulse on the final cycle of the last line
//
// Configuration:
//    US_SCAN_CONT_EN  when defined, frames run back to back after the last
//                     line (frame_done still pulses) until a stop is pending.
//                     When undefined, every frame needs its own start.
// ---------------------------------------------------------------------------
module us_scan_timing_gen #(
   parameter int ENV_WIDTH       = 4,
   parameter int ENV_GAP         = 2,
   parameter int GATE_WIDTH      = 3,
   parameter int GATE_PERIOD     = 8,
   parameter int FOCUS_ZONES     = 3,
   parameter int LINE_GAP        = 5,
   parameter int LINES_PER_FRAME = 128
) (
   input  logic       clk_in,
   input  logic       reset_n,
   input  logic       start,
   input  logic       stop,
   output logic       envelop,
   output logic       rx_gate,
   output logic [7:0] line_idx,
   output logic [1:0] focus_idx,
   output logic       busy,
   output logic       frame_done
);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_ENV      = 3'd1,
      ST_ENV_GAP  = 3'd2,
      ST_GATE_HI  = 3'd3,
      ST_GATE_LO  = 3'd4,
      ST_LINE_GAP = 3'd5
   } state_t;

   // The phase counter is loaded with (duration - 1) on state entry and the
   // state is left on the cycle it reads zero, so every state lasts exactly
   // its programmed number of cycles with no slip between states.
   localparam logic [15:0] ENV_LOAD  = 16'(ENV_WIDTH - 1);
   localparam logic [15:0] EGAP_LOAD = 16'(ENV_GAP - 1);
   localparam logic [15:0] GHI_LOAD  = 16'(GATE_WIDTH - 1);
   localparam logic [15:0] GLO_LOAD  = 16'(GATE_PERIOD - GATE_WIDTH - 1);
   localparam logic [15:0] LGAP_LOAD = 16'(LINE_GAP - 1);
   localparam logic [7:0]  LINE_LAST = 8'(LINES_PER_FRAME - 1);
   localparam logic [1:0]  ZONES     = 2'(FOCUS_ZONES);

   state_t      state_r;
   state_t      state_next_s;
   logic [15:0] phase_r;
   logic [15:0] phase_next_s;
   logic [1:0]  gate_cnt_r;
   logic [1:0]  gate_cnt_next_s;
   logic [7:0]  line_idx_r;
   logic [7:0]  line_idx_next_s;
   logic [1:0]  focus_r;
   logic [1:0]  focus_next_s;
   logic        stop_pend_r;
   logic        stop_pend_next_s;
   logic        envelop_r;
   logic        rx_gate_r;
   logic        busy_r;
   logic        frame_done_r;
   logic        frame_done_next_s;
   logic        phase_done_s;
   logic        stop_req_s;
   logic        line_last_s;

   // Host focus code sequence; 01 is never produced.
   function automatic logic [1:0] focus_advance(input logic [1:0] code);
      logic [1:0] nxt;
      case (code)
         2'b00:   nxt = 2'b10;
         2'b10:   nxt = 2'b11;
         2'b11:   nxt = 2'b00;
         default: nxt = 2'b00;
      endcase
      return nxt;
   endfunction

   assign phase_done_s = (phase_r == 16'd0);
   // A stop arriving on the very last gap cycle still ends the run.
   assign stop_req_s   = stop_pend_r | stop;
   assign line_last_s  = (line_idx_r == LINE_LAST);

   // Next-state, phase counter and line/focus bookkeeping.
   always_comb begin
      state_next_s    = state_r;
      phase_next_s    = phase_done_s ? 16'd0 : (phase_r - 16'd1);
      gate_cnt_next_s = gate_cnt_r;
      line_idx_next_s = line_idx_r;
      focus_next_s    = focus_r;

      case (state_r)
         ST_IDLE: begin
            phase_next_s = 16'd0;
            // stop wins over a simultaneous start
            if (start && !stop) begin
               state_next_s    = ST_ENV;
               phase_next_s    = ENV_LOAD;
               gate_cnt_next_s = 2'd0;
               focus_next_s    = 2'b00;
            end else begin
               state_next_s = ST_IDLE;
            end
         end

         ST_ENV: begin
            if (phase_done_s) begin
               state_next_s = ST_ENV_GAP;
               phase_next_s = EGAP_LOAD;
            end else begin
               state_next_s = ST_ENV;
            end
         end

         ST_ENV_GAP: begin
            if (phase_done_s) begin
               state_next_s    = ST_GATE_HI;
               phase_next_s    = GHI_LOAD;
               gate_cnt_next_s = gate_cnt_r + 2'd1;
               focus_next_s    = focus_advance(focus_r);
            end else begin
               state_next_s = ST_ENV_GAP;
            end
         end

         ST_GATE_HI: begin
            if (phase_done_s) begin
               state_next_s = ST_GATE_LO;
               phase_next_s = GLO_LOAD;
            end else begin
               state_next_s = ST_GATE_HI;
            end
         end

         ST_GATE_LO: begin
            if (phase_done_s) begin
               if (gate_cnt_r < ZONES) begin
                  state_next_s    = ST_GATE_HI;
                  phase_next_s    = GHI_LOAD;
                  gate_cnt_next_s = gate_cnt_r + 2'd1;
                  focus_next_s    = focus_advance(focus_r);
               end else begin
                  state_next_s = ST_LINE_GAP;
                  phase_next_s = LGAP_LOAD;
               end
            end else begin
               state_next_s = ST_GATE_LO;
            end
         end

         ST_LINE_GAP: begin
            if (phase_done_s) begin
               if (line_last_s) begin
                  line_idx_next_s = 8'd0;
`ifdef US_SCAN_CONT_EN
                  if (stop_req_s) begin
                     state_next_s = ST_IDLE;
                     phase_next_s = 16'd0;
                  end else begin
                     state_next_s    = ST_ENV;
                     phase_next_s    = ENV_LOAD;
                     gate_cnt_next_s = 2'd0;
                     focus_next_s    = 2'b00;
                  end
`else
                  state_next_s = ST_IDLE;
                  phase_next_s = 16'd0;
`endif
               end else begin
                  line_idx_next_s = line_idx_r + 8'd1;
                  if (stop_req_s) begin
                     state_next_s = ST_IDLE;
                     phase_next_s = 16'd0;
                  end else begin
                     state_next_s    = ST_ENV;
                     phase_next_s    = ENV_LOAD;
                     gate_cnt_next_s = 2'd0;
                     focus_next_s    = 2'b00;
                  end
               end
            end else begin
               state_next_s = ST_LINE_GAP;
            end
         end

         default: begin
            state_next_s = ST_IDLE;
            phase_next_s = 16'd0;
         end
      endcase
   end

   // Stop-pending flag: set by stop while running, cleared on return to idle.
   always_comb begin
      stop_pend_next_s = stop_pend_r;
      if (state_next_s == ST_IDLE) begin
         stop_pend_next_s = 1'b0;
      end else if (stop && (state_r != ST_IDLE)) begin
         stop_pend_next_s = 1'b1;
      end else begin
         stop_pend_next_s = stop_pend_r;
      end
   end

   // frame_done is registered, so it is raised on entry to the final gap
   // cycle of the last line; line_idx_r is still that line's index there.
   always_comb begin
      frame_done_next_s = 1'b0;
      if ((state_next_s == ST_LINE_GAP) && (phase_next_s == 16'd0) && line_last_s) begin
         frame_done_next_s = 1'b1;
      end else begin
         frame_done_next_s = 1'b0;
      end
   end

   // State, counters and registered pin outputs.
   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         state_r      <= ST_IDLE;
         phase_r      <= 16'd0;
         gate_cnt_r   <= 2'd0;
         line_idx_r   <= 8'd0;
         focus_r      <= 2'b00;
         stop_pend_r  <= 1'b0;
         envelop_r    <= 1'b0;
         rx_gate_r    <= 1'b0;
         busy_r       <= 1'b0;
         frame_done_r <= 1'b0;
      end else begin
         state_r      <= state_next_s;
         phase_r      <= phase_next_s;
         gate_cnt_r   <= gate_cnt_next_s;
         line_idx_r   <= line_idx_next_s;
         focus_r      <= focus_next_s;
         stop_pend_r  <= stop_pend_next_s;
         envelop_r    <= (state_next_s == ST_ENV);
         rx_gate_r    <= (state_next_s == ST_GATE_HI);
         busy_r       <= (state_next_s != ST_IDLE);
         frame_done_r <= frame_done_next_s;
      end
   end

   assign envelop    = envelop_r;
   assign rx_gate    = rx_gate_r;
   assign line_idx   = line_idx_r;
   assign focus_idx  = focus_r;
   assign busy       = busy_r;
   assign frame_done = frame_done_r;

   us_scan_timing_gen_chk u_chk (
      .clk_in     (clk_in),
      .reset_n    (reset_n),
      .envelop    (envelop_r),
      .rx_gate    (rx_gate_r),
      .focus_idx  (focus_r),
      .busy       (busy_r),
      .frame_done (frame_done_r)
   );

endmodule

// ---------------------------------------------------------------------------
// us_scan_timing_gen_chk
//
// Purpose:
//    Pin-level invariants of the timing generator: envelop and rx_gate never
//    overlap or touch, focus code 01 never appears, frame_done only while busy.
//
// Ports:
//    clk_in, reset_n                        clock and async active-low reset
//    envelop, rx_gate, focus_idx, busy,
//    frame_done                             observed generator outputs
// ---------------------------------------------------------------------------
module us_scan_timing_gen_chk (
   input logic       clk_in,
   input logic       reset_n,
   input logic       envelop,
   input logic       rx_gate,
   input logic [1:0] focus_idx,
   input logic       busy,
   input logic       frame_done
);

   a_no_overlap : assert property (@(posedge clk_in) disable iff (!reset_n)
      !(envelop && rx_gate));

   a_gate_after_gap : assert property (@(posedge clk_in) disable iff (!reset_n)
      $rose(rx_gate) |-> !$past(envelop));

   a_no_code01 : assert property (@(posedge clk_in) disable iff (!reset_n)
      focus_idx != 2'b01);

   a_done_busy : assert property (@(posedge clk_in) disable iff (!reset_n)
      frame_done |-> busy);

endmodule

// File: tb/tb_us_scan_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_us_scan_timing_gen
//
// Scoreboard bench for us_scan_timing_gen with LINES_PER_FRAME=4 and the
// default timing (35-cycle lines). Expected pin events (envelop, rx_gate,
// frame_done rises and busy fall) are computed from the line-length model and
// queued when start is driven; a monitor on the falling clock edge pops and
// compares them as the DUT produces them. Cycle numbering: cycle c is the
// interval after the c-th rising edge; start driven in cycle t0 makes envelop
// rise in cycle t0+1.
// ---------------------------------------------------------------------------
module tb_us_scan_timing_gen;

   localparam int LPF      = 4;
   localparam int LINE_LEN = 35;

   logic       clk_in  = 1'b0;
   logic       reset_n = 1'b0;
   logic       start   = 1'b0;
   logic       stop    = 1'b0;
   logic       envelop;
   logic       rx_gate;
   logic [7:0] line_idx;
   logic [1:0] focus_idx;
   logic       busy;
   logic       frame_done;

   us_scan_timing_gen #(
      .LINES_PER_FRAME (LPF)
   ) dut (
      .clk_in     (clk_in),
      .reset_n    (reset_n),
      .start      (start),
      .stop       (stop),
      .envelop    (envelop),
      .rx_gate    (rx_gate),
      .line_idx   (line_idx),
      .focus_idx  (focus_idx),
      .busy       (busy),
      .frame_done (frame_done)
   );

   always #5 clk_in = ~clk_in;

   int cyc = 0;
   always @(posedge clk_in) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      int cyc;
      int val;
      int width;
   } ev_t;

   ev_t env_q[$];
   ev_t gate_q[$];
   int  done_q[$];
   int  idle_q[$];
   int  exp_line = 0;
   int  focus_exp[3] = '{2, 3, 0};

   task automatic check_eq(input string tag, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   // Queue every pin event of n_lines lines starting at first_line, start in t0.
   task automatic push_run(input int t0, input int first_line, input int n_lines);
      ev_t e;
      for (int i = 0; i < n_lines; i++) begin
         int ln;
         int base;
         ln   = (first_line + i) % LPF;
         base = t0 + 1 + LINE_LEN * i;
         e.cyc = base; e.val = ln; e.width = 4;
         env_q.push_back(e);
         for (int g = 0; g < 3; g++) begin
            e.cyc = base + 6 + 8 * g; e.val = focus_exp[g]; e.width = 3;
            gate_q.push_back(e);
         end
         if (ln == LPF - 1) done_q.push_back(base + 34);
      end
      idle_q.push_back(t0 + 1 + LINE_LEN * n_lines);
   endtask

   // ---------------- monitor ----------------
   logic prev_env = 1'b0, prev_gate = 1'b0, prev_done = 1'b0, prev_busy = 1'b0;
   int   env_w = 0, env_w_exp = 0, gate_w = 0, gate_w_exp = 0, done_w = 0;
   int   env_focus_bad = 0, env_rises = 0, sep_err = 0;
   ev_t  mon_e;
   int   mon_i;

   always @(negedge clk_in) begin
      if (!reset_n) begin
         prev_env = 1'b0; prev_gate = 1'b0; prev_done = 1'b0; prev_busy = 1'b0;
         env_w = 0; gate_w = 0; done_w = 0;
      end else begin
         if ((envelop && rx_gate) || (rx_gate && !prev_gate && prev_env) ||
             (envelop && !prev_env && prev_gate)) sep_err++;

         if (envelop && !prev_env) begin
            env_rises++;
            env_w = 1;
            env_focus_bad = (focus_idx != 2'b00) ? 1 : 0;
            if (env_q.size() == 0) check_eq("env_unexpected", 1, 0);
            else begin
               mon_e = env_q.pop_front();
               check_eq("env_rise_cycle", cyc, mon_e.cyc);
               check_eq("env_line_idx", int'(line_idx), mon_e.val);
               env_w_exp = mon_e.width;
            end
         end else if (envelop) begin
            env_w++;
            if (focus_idx != 2'b00) env_focus_bad++;
         end else if (prev_env) begin
            check_eq("env_width", env_w, env_w_exp);
            check_eq("env_focus00", env_focus_bad, 0);
         end

         if (rx_gate && !prev_gate) begin
            gate_w = 1;
            if (gate_q.size() == 0) check_eq("gate_unexpected", 1, 0);
            else begin
               mon_e = gate_q.pop_front();
               check_eq("gate_rise_cycle", cyc, mon_e.cyc);
               check_eq("gate_focus", int'(focus_idx), mon_e.val);
               gate_w_exp = mon_e.width;
            end
         end else if (rx_gate) begin
            gate_w++;
         end else if (prev_gate) begin
            check_eq("gate_width", gate_w, gate_w_exp);
         end

         if (frame_done && !prev_done) begin
            done_w = 1;
            if (done_q.size() == 0) check_eq("done_unexpected", 1, 0);
            else begin
               mon_i = done_q.pop_front();
               check_eq("done_cycle", cyc, mon_i);
            end
         end else if (frame_done) begin
            done_w++;
         end else if (prev_done) begin
            check_eq("done_width", done_w, 1);
         end

         if (!busy && prev_busy) begin
            if (idle_q.size() == 0) check_eq("idle_unexpected", 1, 0);
            else begin
               mon_i = idle_q.pop_front();
               check_eq("busy_fall_cycle", cyc, mon_i);
            end
         end

         prev_env  = envelop;
         prev_gate = rx_gate;
         prev_done = frame_done;
         prev_busy = busy;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick_to(input int target);
      while (cyc < target) begin
         @(posedge clk_in); #1;
      end
   endtask

   task automatic pulse_start(output int t0);
      @(posedge clk_in); #1;
      start = 1'b1;
      t0 = cyc;
      @(posedge clk_in); #1;
      start = 1'b0;
   endtask

   task automatic pulse_stop();
      stop = 1'b1;
      @(posedge clk_in); #1;
      stop = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int n;
      n = 0;
      while (busy && n < budget) begin
         @(posedge clk_in); #1;
         n++;
      end
      check_eq({tag, "_idle_in_budget"}, busy ? 0 : 1, 1);
      @(posedge clk_in); #1;
   endtask

   task automatic check_drained(input string tag);
      check_eq({tag, "_env_left"},  env_q.size(),  0);
      check_eq({tag, "_gate_left"}, gate_q.size(), 0);
      check_eq({tag, "_done_left"}, done_q.size(), 0);
      check_eq({tag, "_idle_left"}, idle_q.size(), 0);
      check_eq({tag, "_separation"}, sep_err, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0;
      int rises0;
      int act_cnt;

      // Reset state
      repeat (3) @(posedge clk_in);
      #1;
      check_eq("rst_envelop",    int'(envelop),    0);
      check_eq("rst_rx_gate",    int'(rx_gate),    0);
      check_eq("rst_line_idx",   int'(line_idx),   0);
      check_eq("rst_focus_idx",  int'(focus_idx),  0);
      check_eq("rst_busy",       int'(busy),       0);
      check_eq("rst_frame_done", int'(frame_done), 0);
      @(posedge clk_in); #1;
      reset_n = 1'b1;
      repeat (2) begin @(posedge clk_in); #1; end

      // Full frame; a second start while busy must not disturb timing
      rises0 = env_rises;
      pulse_start(t0);
`ifdef US_SCAN_CONT_EN
      push_run(t0, exp_line, LPF + 1);
      tick_to(t0 + 50);
      pulse_start(act_cnt);
      tick_to(t0 + 150);
      pulse_stop();
      exp_line = (exp_line + LPF + 1) % LPF;
      wait_idle("frame", 400);
      check_eq("frame_host_lines", env_rises - rises0, LPF + 1);
`else
      push_run(t0, exp_line, LPF);
      tick_to(t0 + 50);
      pulse_start(act_cnt);
      exp_line = (exp_line + LPF) % LPF;
      wait_idle("frame", 400);
      check_eq("frame_host_lines", env_rises - rises0, LPF);
`endif
      check_eq("frame_line_idx", int'(line_idx), exp_line);
      check_drained("frame");

      // Stop during a gate of the second line: that line completes, then idle
      pulse_start(t0);
      push_run(t0, exp_line, 2);
      tick_to(t0 + 43);
      check_eq("stop_mid_gate_rx", int'(rx_gate), 1);
      pulse_stop();
      exp_line = (exp_line + 2) % LPF;
      wait_idle("stop", 200);
      check_eq("stop_line_idx", int'(line_idx), exp_line);
      check_drained("stop");

      // start and stop together in idle: nothing happens
      @(posedge clk_in); #1;
      start = 1'b1;
      stop  = 1'b1;
      @(posedge clk_in); #1;
      start = 1'b0;
      stop  = 1'b0;
      act_cnt = 0;
      repeat (10) begin
         if (busy || envelop) act_cnt++;
         @(posedge clk_in); #1;
      end
      check_eq("start_stop_activity", act_cnt, 0);
      check_eq("start_stop_line_idx", int'(line_idx), exp_line);

      // Asynchronous reset during the first gate of a line
      pulse_start(t0);
      begin
         ev_t e;
         e.cyc = t0 + 1; e.val = exp_line; e.width = 4;
         env_q.push_back(e);
         e.cyc = t0 + 7; e.val = focus_exp[0]; e.width = 3;
         gate_q.push_back(e);
      end
      tick_to(t0 + 8);
      check_eq("pre_reset_rx_gate", int'(rx_gate), 1);
      reset_n = 1'b0;
      #1;
      check_eq("arst_rx_gate",   int'(rx_gate),   0);
      check_eq("arst_envelop",   int'(envelop),   0);
      check_eq("arst_line_idx",  int'(line_idx),  0);
      check_eq("arst_focus_idx", int'(focus_idx), 0);
      check_eq("arst_busy",      int'(busy),      0);
      repeat (2) begin @(posedge clk_in); #1; end
      reset_n = 1'b1;
      exp_line = 0;
      @(posedge clk_in); #1;
      check_drained("arst");

      // Frame after reset, with a stop pending in the final line
      pulse_start(t0);
      push_run(t0, 0, LPF);
      tick_to(t0 + 110);
      pulse_stop();
      wait_idle("post_rst", 400);
      check_eq("post_rst_line_idx", int'(line_idx), 0);
      check_drained("post_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
